// File: rtl/elbeth_pc_unit.sv
// ELBETH fetch-stage program-counter unit.
// Holds the architectural PC, produces pc+INC, and arbitrates the next PC between
// exception vector, taken branch (possibly held across a stall), stall hold and
// sequential increment.
// Optional return-address stack: define ELBETH_PC_RAS_EN.
module elbeth_pc_unit #(
    parameter int unsigned      WIDTH        = 32,
    parameter int unsigned      INC          = 4,
    parameter int unsigned      ALIGN_BITS   = 2,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0000_0000),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0100),
    parameter int unsigned      RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             call,
    input  logic             ret,
    input  logic             exception,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_seq,
    output logic             pc_valid,
    output logic [WIDTH-1:0] epc,
    output logic             misalign,
    output logic             redirect_pending,
    output logic             ras_empty
);

    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

    logic [WIDTH-1:0] pend_target;
    logic             pend_call;
    logic             pend_ret;

    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] epc_d;
    logic             misalign_d;
    logic             pend_valid_d;
    logic [WIDTH-1:0] pend_target_d;
    logic             pend_call_d;
    logic             pend_ret_d;

    logic             e_valid;
    logic [WIDTH-1:0] e_target;
    logic             e_call;
    logic             e_ret;
    logic [WIDTH-1:0] apply_target;
    logic             ras_push;
    logic             ras_pop;
    logic [WIDTH-1:0] ras_top;

    // Sequential PC wraps silently past all-ones
    assign pc_seq = pc + WIDTH'(INC);

    // Effective redirect: a fresh branch overrides any held one; call wins over ret
    assign e_valid  = branch_taken | redirect_pending;
    assign e_target = branch_taken ? branch_target : pend_target;
    assign e_call   = branch_taken ? call : pend_call;
    assign e_ret    = branch_taken ? (ret & ~call) : pend_ret;

`ifdef ELBETH_PC_RAS_EN
    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ras_wr_ptr;
    logic [PTR_W-1:0] ras_top_idx;
    logic [CNT_W-1:0] ras_count;

    assign ras_top_idx = (ras_wr_ptr == '0) ? PTR_W'(RAS_DEPTH - 1) : ras_wr_ptr - PTR_W'(1);
    assign ras_top     = ras_mem[ras_top_idx];
    assign ras_empty   = (ras_count == '0);

    // Circular return-address stack: overflow overwrites oldest, count saturates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ras_wr_ptr <= '0;
            ras_count  <= '0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                ras_mem[i] <= '0;
            end
        end else if (ras_push) begin
            ras_mem[ras_wr_ptr] <= pc_seq;
            ras_wr_ptr <= (ras_wr_ptr == PTR_W'(RAS_DEPTH - 1)) ? '0 : ras_wr_ptr + PTR_W'(1);
            if (ras_count != CNT_W'(RAS_DEPTH)) begin
                ras_count <= ras_count + CNT_W'(1);
            end
        end else if (ras_pop) begin
            ras_wr_ptr <= ras_top_idx;
            ras_count  <= ras_count - CNT_W'(1);
        end
    end
`else
    logic unused_ras_inputs;

    assign ras_top           = '0;
    assign ras_empty         = 1'b1;
    assign unused_ras_inputs = ^{e_call, e_ret, ras_push, ras_pop, ras_top};
`endif

    // Next-PC arbitration: exception, redirect (hold or apply), stall, increment
    always_comb begin
        pc_d          = pc;
        epc_d         = epc;
        misalign_d    = 1'b0;
        pend_valid_d  = redirect_pending;
        pend_target_d = pend_target;
        pend_call_d   = pend_call;
        pend_ret_d    = pend_ret;
        apply_target  = e_target;
        ras_push      = 1'b0;
        ras_pop       = 1'b0;

        if (exception) begin
            pc_d          = EXC_VECTOR;
            epc_d         = pc;
            pend_valid_d  = 1'b0;
            pend_target_d = '0;
            pend_call_d   = 1'b0;
            pend_ret_d    = 1'b0;
        end else if (e_valid) begin
            if (stall) begin
                pend_valid_d  = 1'b1;
                pend_target_d = e_target;
                pend_call_d   = e_call;
                pend_ret_d    = e_ret;
            end else begin
                pend_valid_d  = 1'b0;
                pend_target_d = '0;
                pend_call_d   = 1'b0;
                pend_ret_d    = 1'b0;
`ifdef ELBETH_PC_RAS_EN
                if (e_call) begin
                    ras_push = 1'b1;
                end else if (e_ret && !ras_empty) begin
                    ras_pop      = 1'b1;
                    apply_target = ras_top;
                end
`endif
                if ((apply_target & ALIGN_MASK) != '0) begin
                    pc_d       = EXC_VECTOR;
                    epc_d      = apply_target;
                    misalign_d = 1'b1;
                end else begin
                    pc_d = apply_target;
                end
            end
        end else if (!stall) begin
            pc_d = pc_seq;
        end
    end

    // Architectural state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc               <= RESET_VECTOR;
            epc              <= '0;
            misalign         <= 1'b0;
            pc_valid         <= 1'b0;
            redirect_pending <= 1'b0;
            pend_target      <= '0;
            pend_call        <= 1'b0;
            pend_ret         <= 1'b0;
        end else begin
            pc               <= pc_d;
            epc              <= epc_d;
            misalign         <= misalign_d;
            pc_valid         <= 1'b1;
            redirect_pending <= pend_valid_d;
            pend_target      <= pend_target_d;
            pend_call        <= pend_call_d;
            pend_ret         <= pend_ret_d;
        end
    end

endmodule

// File: tb/tb_elbeth_pc_unit.sv
// Directed testbench for elbeth_pc_unit: a 32-bit instance (RAS_DEPTH=2) and an
// 8-bit instance for the wrap-around case.
module tb_elbeth_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        call;
    logic        ret;
    logic        exception;
    logic [31:0] pc;
    logic [31:0] pc_seq;
    logic        pc_valid;
    logic [31:0] epc;
    logic        misalign;
    logic        redirect_pending;
    logic        ras_empty;

    logic [7:0]  s_target;
    logic [7:0]  s_pc;
    logic [7:0]  s_pc_seq;
    logic        s_pc_valid;
    logic [7:0]  s_epc;
    logic        s_misalign;
    logic        s_pending;
    logic        s_ras_empty;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    elbeth_pc_unit #(
        .WIDTH(32), .INC(4), .ALIGN_BITS(2),
        .RESET_VECTOR(32'h0), .EXC_VECTOR(32'h100), .RAS_DEPTH(2)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .call(call), .ret(ret), .exception(exception),
        .pc(pc), .pc_seq(pc_seq), .pc_valid(pc_valid), .epc(epc),
        .misalign(misalign), .redirect_pending(redirect_pending),
        .ras_empty(ras_empty)
    );

    elbeth_pc_unit #(
        .WIDTH(8), .INC(4), .ALIGN_BITS(2),
        .RESET_VECTOR(8'hF4), .EXC_VECTOR(8'h80), .RAS_DEPTH(2)
    ) dut8 (
        .clk(clk), .rst(rst), .stall(1'b0),
        .branch_taken(1'b0), .branch_target(s_target),
        .call(1'b0), .ret(1'b0), .exception(1'b0),
        .pc(s_pc), .pc_seq(s_pc_seq), .pc_valid(s_pc_valid), .epc(s_epc),
        .misalign(s_misalign), .redirect_pending(s_pending),
        .ras_empty(s_ras_empty)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic bt, input logic [31:0] tgt, input logic c,
                         input logic r, input logic st, input logic ex);
        branch_taken  = bt;
        branch_target = tgt;
        call          = c;
        ret           = r;
        stall         = st;
        exception     = ex;
    endtask

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        s_target = 8'h0;
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        #12;
        chk("rst_pc", pc, 32'h0);
        chk("rst_valid", {31'b0, pc_valid}, 32'h0);
        chk("rst_pending", {31'b0, redirect_pending}, 32'h0);
        chk("rst_epc", epc, 32'h0);
        chk("rst_ras_empty", {31'b0, ras_empty}, 32'h1);
        chk("rst_s_pc", {24'b0, s_pc}, 32'hF4);

        // Free run after reset; the 8-bit instance wraps through 0xFC
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("run_pc1", pc, 32'h4);
        chk("run_valid", {31'b0, pc_valid}, 32'h1);
        chk("s_pc1", {24'b0, s_pc}, 32'hF8);
        step();
        chk("run_pc2", pc, 32'h8);
        chk("s_pc2", {24'b0, s_pc}, 32'hFC);
        chk("s_pc_seq_wrap", {24'b0, s_pc_seq}, 32'h00);
        step();
        chk("run_pc3", pc, 32'hC);
        chk("s_pc_wrap", {24'b0, s_pc}, 32'h00);
        chk("s_no_misalign", {31'b0, s_misalign}, 32'h0);
        chk("run_pc_seq", pc_seq, 32'h10);

        // Redirect held across a three-cycle stall
        drive(1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("br_pc20", pc, 32'h20);
        drive(1'b1, 32'h80, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        chk("hold_pc1", pc, 32'h20);
        chk("hold_pend1", {31'b0, redirect_pending}, 32'h1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        chk("hold_pc2", pc, 32'h20);
        chk("hold_pend2", {31'b0, redirect_pending}, 32'h1);
        step();
        chk("hold_pc3", pc, 32'h20);
        chk("hold_pend3", {31'b0, redirect_pending}, 32'h1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("release_pc", pc, 32'h80);
        chk("release_pend", {31'b0, redirect_pending}, 32'h0);
        step();
        chk("after_release_pc", pc, 32'h84);

        // Misaligned redirect traps with a one-cycle misalign pulse
        drive(1'b1, 32'h42, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("mis_pc", pc, 32'h100);
        chk("mis_epc", epc, 32'h42);
        chk("mis_pulse", {31'b0, misalign}, 32'h1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("mis_pulse_end", {31'b0, misalign}, 32'h0);
        chk("mis_seq_pc", pc, 32'h104);

        // Exception under stall discards the pending redirect
        drive(1'b1, 32'h30, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("exc_setup_pc", pc, 32'h30);
        drive(1'b1, 32'h80, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        chk("exc_setup_pend", {31'b0, redirect_pending}, 32'h1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        chk("exc_pc", pc, 32'h100);
        chk("exc_epc", epc, 32'h30);
        chk("exc_pend_clr", {31'b0, redirect_pending}, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("exc_resume_pc", pc, 32'h104);

        // A newer branch during stall replaces the held one
        drive(1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b1, 32'h300, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        chk("ovw_hold_pc", pc, 32'h104);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("ovw_pc", pc, 32'h300);

`ifdef ELBETH_PC_RAS_EN
        // Three calls into a two-entry stack, then three returns
        drive(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("ras_start_pc", pc, 32'h10);
        drive(1'b1, 32'h20, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk("call1_pc", pc, 32'h20);
        drive(1'b1, 32'h30, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk("call2_pc", pc, 32'h30);
        drive(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk("call3_pc", pc, 32'h40);
        chk("ras_full", {31'b0, ras_empty}, 32'h0);
        drive(1'b1, 32'h900, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        chk("ret1_pc", pc, 32'h34);
        step();
        chk("ret2_pc", pc, 32'h24);
        chk("ras_empty_after2", {31'b0, ras_empty}, 32'h1);
        step();
        chk("ret3_pc", pc, 32'h900);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
`else
        // Without the stack, ret/call are ordinary branches
        drive(1'b1, 32'h500, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        chk("ret_plain_pc", pc, 32'h500);
        chk("ras_tied", {31'b0, ras_empty}, 32'h1);
        drive(1'b1, 32'h600, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk("call_plain_pc", pc, 32'h600);
        chk("ras_tied2", {31'b0, ras_empty}, 32'h1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

        // Asynchronous reset in the middle of a stall
        drive(1'b1, 32'h700, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_pc", pc, 32'h0);
        chk("async_rst_pend", {31'b0, redirect_pending}, 32'h0);
        chk("async_rst_valid", {31'b0, pc_valid}, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("post_rst_pc", pc, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
